// File: rtl/f_npc_fetch.sv
// f_npc_fetch: fetch-stage PC register and next-PC selection.
//   npc_sel: 0=pc4, 1=j, 2=rs, 3=b (branch taken only when b_j=1); others act as pc4.
//   Optional feature macro NPC_EXC_EN adds exception/eret redirects, the
//   FETCH/REDIR FSM with its held redirect target, and fetch address errors.
//   Handshake: imem_req/imem_addr present a fetch; imem_ready=1 means the word at
//   imem_addr is delivered this cycle, and F_pc may only move on such a cycle
//   (or when a fetch address error makes the request void).
//   dbg_state exposes the FSM state (0=FETCH, 1=REDIR) for checkers.
module f_npc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] D_pc,
  input  logic [25:0] imm26,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_d,
  input  logic [2:0]  npc_sel,
  input  logic        b_j,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] F_pc,
  output logic        F_valid,
  output logic        F_adel,
  output logic [31:0] npc,
  output logic        dbg_state
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] seq_npc;
  logic [31:0] br_off;

  // Sequential next PC from the npc_sel table; all adds wrap modulo 2^32.
  always_comb begin
    br_off  = {{14{imm16[15]}}, imm16, 2'b00};
    seq_npc = pc_q + 32'd4;
    case (npc_sel)
      3'd1:    seq_npc = {D_pc[31:28], imm26, 2'b00};
      3'd2:    seq_npc = rs_d;
      3'd3:    if (b_j) seq_npc = D_pc + 32'd4 + br_off;
      default: seq_npc = pc_q + 32'd4;
    endcase
  end

`ifdef NPC_EXC_EN
  typedef enum logic {FETCH = 1'b0, REDIR = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        adel;
  logic        eff_ready;

  // exc_req outranks eret when both arrive together.
  assign redir     = exc_req | eret;
  assign redir_tgt = exc_req ? HANDLER_PC : epc;
  assign adel      = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
  // A faulting address issues no request, so there is nothing to wait for.
  assign eff_ready = imem_ready | adel;

  // Next-state logic: redirects wait for the outstanding fetch before landing.
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    pc_d       = pc_q;
    case (state_q)
      FETCH: begin
        if (redir) begin
          if (eff_ready) begin
            pc_d = redir_tgt;
          end else begin
            redir_pc_d = redir_tgt;
            state_d    = REDIR;
          end
        end else if (eff_ready && !stall) begin
          pc_d = seq_npc;
        end
      end
      REDIR: begin
        if (redir) redir_pc_d = redir_tgt;
        if (eff_ready) begin
          pc_d    = redir ? redir_tgt : redir_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State registers; reset dominates stall and any redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      redir_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      pc_q       <= pc_d;
    end
  end

  assign npc       = redir ? redir_tgt : seq_npc;
  assign F_adel    = adel;
  assign F_valid   = !reset &&
                     ((imem_ready && (state_q == FETCH) && !exc_req && !eret && !adel) ||
                      (adel && (state_q == FETCH) && !redir));
  assign imem_req  = !reset && !adel;
  assign dbg_state = (state_q == REDIR);
`else
  logic unused_exc;
  assign unused_exc = ^{exc_req, eret, epc};

  // Advance only when the current fetch completes and D is not stalling.
  always_comb begin
    pc_d = pc_q;
    if (imem_ready && !stall) pc_d = seq_npc;
  end

  // PC register; reset dominates stall.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign npc       = seq_npc;
  assign F_adel    = 1'b0;
  assign F_valid   = !reset && imem_ready;
  assign imem_req  = !reset;
  assign dbg_state = 1'b0;
`endif

  assign F_pc      = pc_q;
  assign imem_addr = pc_q;

endmodule

// File: doc/f_npc_fetch.md
F_NPC_FETCH -- requirements
Module: f_npc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the exception entry address.
REQ-003 SHALL have parameter TEXT_LO, default 32'h0000_3000, meaning the lowest legal fetch address.
REQ-004 SHALL have parameter TEXT_HI, default 32'h0000_6ffc, meaning the highest legal fetch address.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard stall from D; F holds.
- D_pc  in  32  PC of the instruction in D.
- imm26  in  26  jump index.
- imm16  in  16  branch offset.
- rs_d  in  32  forwarded rs value.
- npc_sel  in  3  0=pc4, 1=j, 2=rs, 3=b; other codes are treated as pc4.
- b_j  in  1  branch condition true.
- exc_req  in  1  exception redirect.
- eret  in  1  return redirect.
- epc  in  32  return target.
- imem_ready  in  1  instruction valid for imem_addr this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  equals F_pc.
- F_pc  out  32  fetch PC register.
- F_valid  out  1  instruction at F_pc is passed to D this cycle.
- F_adel  out  1  fetch address error.
- npc  out  32  combinational next PC.

Function
REQ-006 npc SHALL be selected by priority: exc_req gives HANDLER_PC; otherwise eret gives epc; otherwise the npc_sel table applies.
REQ-007 The npc_sel table SHALL be: pc4 gives F_pc+4; j gives {D_pc[31:28],imm26,2'b00}; rs gives rs_d; b with b_j=1 gives D_pc+4+sign-extended(imm16)<<2; b with b_j=0 gives F_pc+4. All additions are 32-bit and wrap modulo 2^32.
REQ-008 The FSM SHALL have states FETCH and REDIR; reset enters FETCH.
REQ-009 In FETCH with imem_ready=1, stall=0 and no redirect, F_pc SHALL load npc on the next edge.
REQ-010 In FETCH with stall=1 and no redirect, F_pc SHALL hold; imem_addr stays stable and imem keeps imem_ready asserted.
REQ-011 In FETCH with imem_ready=0 and no redirect, F_pc SHALL hold and F_valid SHALL be 0.
REQ-012 A redirect (exc_req or eret) in FETCH with imem_ready=1 SHALL load F_pc with the redirect target next edge, regardless of stall.
REQ-013 A redirect in FETCH with imem_ready=0 SHALL store the target in redir_pc and enter REDIR; F_pc holds so that the outstanding request completes.
REQ-014 In REDIR, a new redirect SHALL overwrite redir_pc, so the newest target wins.
REQ-015 In REDIR, when imem_ready=1, F_pc SHALL load redir_pc, or the new redirect target if one is present that same cycle, and the FSM returns to FETCH.
REQ-016 F_valid SHALL be imem_ready and state==FETCH and not exc_req and not eret and not F_adel, OR'd with (F_adel and state==FETCH and no redirect).
REQ-017 imem_req SHALL be 1 in every cycle except the reset cycle and cycles where F_adel=1.
REQ-018 F_adel SHALL be 1 when F_pc[1:0]!=0, F_pc<TEXT_LO or F_pc>TEXT_HI. When F_adel=1, imem_ready is ignored and advance is gated by stall only.
REQ-019 Simultaneous exc_req and eret SHALL resolve to exc_req.

Reset
REQ-020 While reset=1, the following SHALL hold on the next edge: F_pc=RESET_PC, state=FETCH, redir_pc=RESET_PC, imem_req=0, F_valid=0.
REQ-021 Reset asserted in REDIR SHALL discard redir_pc; the next fetch uses RESET_PC.
REQ-022 Reset SHALL have priority over stall, exc_req and eret.

Configuration
REQ-023 Macro NPC_EXC_EN, when defined, SHALL compile in exc_req, eret, epc handling, the REDIR state, redir_pc and F_adel.
REQ-024 Without NPC_EXC_EN, the block SHALL ignore exc_req, eret and epc, tie F_adel to 0 and contain no REDIR state; npc follows the npc_sel table only.

Verification
REQ-025 After reset with imem_ready=1, stall=0 and npc_sel=0 for 3 cycles, F_pc SHALL step 3000, 3004, 3008, 300c.
REQ-026 With D_pc=3010, npc_sel=3, b_j=1 and imem16=16'hfffe, npc SHALL be 300c and F_pc SHALL load 300c next edge; with b_j=0, npc SHALL be F_pc+4.
REQ-027 With stall=1 for 2 cycles at F_pc=3008, F_pc SHALL hold 3008; with exc_req pulsed during the stall, F_pc SHALL become 4180 next edge.
REQ-028 With imem_ready=0 and eret pulsed with epc=3100, followed by exc_req 2 cycles later and then imem_ready=1, F_pc SHALL become 4180 and F_valid SHALL be 0 throughout REDIR.
REQ-029 With npc_sel=2 and rs_d=3002, F_pc SHALL be 3002, F_adel=1, imem_req=0 and F_valid=1; with rs_d=7000, F_adel SHALL likewise be 1.
REQ-030 With reset asserted while in REDIR holding redir_pc=3200, F_pc SHALL be 3000 next edge and state SHALL be FETCH.
